// File: rtl/hazard_sched_if.sv
// Decode/Execute/Memory hazard inputs and pipeline-register control outputs of the hazard scheduler.
// master = pipeline side driving stage status, slave = scheduler.
interface hazard_sched_if #(
    parameter int REG_W = 5
) ();
    logic             d_valid;
    logic [REG_W-1:0] d_rs;
    logic [REG_W-1:0] d_rt;
    logic             d_use_rs;
    logic             d_use_rt;
    logic             d_is_fpu;
    logic [REG_W-1:0] d_fs;
    logic [REG_W-1:0] d_ft;
    logic             d_use_fs;
    logic             d_use_ft;
    logic             x_valid;
    logic             x_mem_read;
    logic [REG_W-1:0] x_dst;
    logic             x_fpu_start;
    logic [REG_W-1:0] x_fpu_dst;
    logic             m_branch_taken;
    logic             pc_hold;
    logic             fd_hold;
    logic             fd_bubble;
    logic             dx_bubble;
    logic             xm_bubble;
    logic             fpu_busy;
    logic             fpu_done;
    logic [REG_W-1:0] fpu_dst_o;
    logic             fpu_overlap_err;

    modport master (
        output d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_is_fpu, d_fs, d_ft, d_use_fs, d_use_ft,
        output x_valid, x_mem_read, x_dst, x_fpu_start, x_fpu_dst, m_branch_taken,
        input  pc_hold, fd_hold, fd_bubble, dx_bubble, xm_bubble,
        input  fpu_busy, fpu_done, fpu_dst_o, fpu_overlap_err
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_is_fpu, d_fs, d_ft, d_use_fs, d_use_ft,
        input  x_valid, x_mem_read, x_dst, x_fpu_start, x_fpu_dst, m_branch_taken,
        output pc_hold, fd_hold, fd_bubble, dx_bubble, xm_bubble,
        output fpu_busy, fpu_done, fpu_dst_o, fpu_overlap_err
    );
endinterface

// File: rtl/hazard_sched.sv
// Pipeline hazard scheduler: branch flush, FPU structural/data stall, load-use stall, FPU occupancy FSM.
// Hold/bubble outputs are combinational and act at the next edge; FPU stays busy FPU_LAT cycles after issue.
module hazard_sched #(
    parameter int REG_W   = 5,
    parameter int FPU_LAT = 4,
    parameter int CNT_W   = 3
) (
    input logic         clk,
    input logic         rst,
    hazard_sched_if.slave hs
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REG_W-1:0]   busy_dst_q, busy_dst_d;
    logic               overlap_err_q, overlap_err_d;

    logic busy;
    logic fpu_hit;
    logic lu_hit;

    assign busy = (state_q == BUSY);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        busy_dst_d    = busy_dst_q;
        overlap_err_d = overlap_err_q | (hs.x_fpu_start & busy);
        case (state_q)
            IDLE: begin
                // A start alongside a taken branch is younger than the branch and gets killed.
                if (hs.x_fpu_start && !hs.m_branch_taken) begin
                    state_d    = BUSY;
                    cnt_d      = CNT_W'(FPU_LAT - 1);
                    busy_dst_d = hs.x_fpu_dst;
                end
            end
            BUSY: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            busy_dst_q    <= '0;
            overlap_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            busy_dst_q    <= busy_dst_d;
            overlap_err_q <= overlap_err_d;
        end
    end

    assign fpu_hit = busy & hs.d_valid &
                     (hs.d_is_fpu |
                      (hs.d_use_fs & (hs.d_fs == busy_dst_q)) |
                      (hs.d_use_ft & (hs.d_ft == busy_dst_q)));

    assign lu_hit = hs.x_valid & hs.x_mem_read & (hs.x_dst != '0) & hs.d_valid &
                    ((hs.d_use_rs & (hs.d_rs == hs.x_dst)) |
                     (hs.d_use_rt & (hs.d_rt == hs.x_dst)));

    always_comb begin
        hs.pc_hold   = 1'b0;
        hs.fd_hold   = 1'b0;
        hs.fd_bubble = 1'b0;
        hs.dx_bubble = 1'b0;
        hs.xm_bubble = 1'b0;
        if (!rst || hs.m_branch_taken) begin
            hs.fd_bubble = 1'b1;
            hs.dx_bubble = 1'b1;
            hs.xm_bubble = 1'b1;
        end else if (fpu_hit || lu_hit) begin
            hs.pc_hold   = 1'b1;
            hs.fd_hold   = 1'b1;
            hs.dx_bubble = 1'b1;
        end
    end

    assign hs.fpu_busy        = rst & busy;
    assign hs.fpu_done        = rst & busy & (cnt_q == '0);
    assign hs.fpu_dst_o       = rst ? busy_dst_q : '0;
    assign hs.fpu_overlap_err = overlap_err_q;
endmodule

// File: tb/tb_hazard_sched.sv
// Scoreboard bench for hazard_sched: directed test-plan sequences then random stimulus vs a cycle-count model.
module tb_hazard_sched;
    localparam int REG_W   = 5;
    localparam int FPU_LAT = 4;
    localparam int CNT_W   = 3;

    typedef struct packed {
        logic             rst;
        logic             d_valid;
        logic [REG_W-1:0] d_rs;
        logic [REG_W-1:0] d_rt;
        logic             d_use_rs;
        logic             d_use_rt;
        logic             d_is_fpu;
        logic [REG_W-1:0] d_fs;
        logic [REG_W-1:0] d_ft;
        logic             d_use_fs;
        logic             d_use_ft;
        logic             x_valid;
        logic             x_mem_read;
        logic [REG_W-1:0] x_dst;
        logic             x_fpu_start;
        logic [REG_W-1:0] x_fpu_dst;
        logic             m_branch_taken;
    } stim_t;

    typedef struct packed {
        logic             pc_hold;
        logic             fd_hold;
        logic             fd_bubble;
        logic             dx_bubble;
        logic             xm_bubble;
        logic             fpu_busy;
        logic             fpu_done;
        logic [REG_W-1:0] fpu_dst_o;
        logic             fpu_overlap_err;
    } exp_t;

    logic clk;
    logic rst;
    hazard_sched_if #(.REG_W(REG_W)) bus ();

    hazard_sched #(.REG_W(REG_W), .FPU_LAT(FPU_LAT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hs  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   tag_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Model: remaining FPU cycles (0 = free), destination, sticky overlap flag.
    int               m_rem = 0;
    logic [REG_W-1:0] m_dst = '0;
    logic             m_err = 1'b0;

    function automatic exp_t model_out(input stim_t s);
        exp_t e;
        logic fpu_stall, lu_stall;
        e = '0;
        e.fpu_overlap_err = m_err;
        if (!s.rst) begin
            e.fd_bubble = 1'b1; e.dx_bubble = 1'b1; e.xm_bubble = 1'b1;
            return e;
        end
        e.fpu_busy  = (m_rem > 0);
        e.fpu_done  = (m_rem == 1);
        e.fpu_dst_o = m_dst;
        fpu_stall = (m_rem > 0) && s.d_valid &&
                    (s.d_is_fpu || (s.d_use_fs && s.d_fs == m_dst) || (s.d_use_ft && s.d_ft == m_dst));
        lu_stall  = s.x_valid && s.x_mem_read && s.x_dst != 0 && s.d_valid &&
                    ((s.d_use_rs && s.d_rs == s.x_dst) || (s.d_use_rt && s.d_rt == s.x_dst));
        if (s.m_branch_taken) begin
            e.fd_bubble = 1'b1; e.dx_bubble = 1'b1; e.xm_bubble = 1'b1;
        end else if (fpu_stall || lu_stall) begin
            e.pc_hold = 1'b1; e.fd_hold = 1'b1; e.dx_bubble = 1'b1;
        end
        return e;
    endfunction

    task automatic model_edge(input stim_t s);
        if (!s.rst) begin
            m_rem = 0; m_dst = '0; m_err = 1'b0;
        end else begin
            if (s.x_fpu_start && m_rem > 0) m_err = 1'b1;
            if (m_rem > 0) m_rem = m_rem - 1;
            else if (s.x_fpu_start && !s.m_branch_taken) begin
                m_rem = FPU_LAT;
                m_dst = s.x_fpu_dst;
            end
        end
    endtask

    task automatic apply(input stim_t s);
        rst                = s.rst;
        bus.d_valid        = s.d_valid;
        bus.d_rs           = s.d_rs;
        bus.d_rt           = s.d_rt;
        bus.d_use_rs       = s.d_use_rs;
        bus.d_use_rt       = s.d_use_rt;
        bus.d_is_fpu       = s.d_is_fpu;
        bus.d_fs           = s.d_fs;
        bus.d_ft           = s.d_ft;
        bus.d_use_fs       = s.d_use_fs;
        bus.d_use_ft       = s.d_use_ft;
        bus.x_valid        = s.x_valid;
        bus.x_mem_read     = s.x_mem_read;
        bus.x_dst          = s.x_dst;
        bus.x_fpu_start    = s.x_fpu_start;
        bus.x_fpu_dst      = s.x_fpu_dst;
        bus.m_branch_taken = s.m_branch_taken;
    endtask

    // Drive one cycle (just after an edge), queue its expected outputs, advance the model at the next edge.
    task automatic step(input stim_t s);
        apply(s);
        exp_q.push_back(model_out(s));
        tag_q.push_back(cyc);
        @(posedge clk);
        model_edge(s);
        cyc++;
        #1;
    endtask

    function automatic stim_t quiet();
        stim_t s;
        s = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e, a;
            int   t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a.pc_hold         = bus.pc_hold;
            a.fd_hold         = bus.fd_hold;
            a.fd_bubble       = bus.fd_bubble;
            a.dx_bubble       = bus.dx_bubble;
            a.xm_bubble       = bus.xm_bubble;
            a.fpu_busy        = bus.fpu_busy;
            a.fpu_done        = bus.fpu_done;
            a.fpu_dst_o       = bus.fpu_dst_o;
            a.fpu_overlap_err = bus.fpu_overlap_err;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL sched_out cyc=%0d got hold(pc,fd)=%b%b bub(fd,dx,xm)=%b%b%b busy=%b done=%b dst=%0d err=%b want hold=%b%b bub=%b%b%b busy=%b done=%b dst=%0d err=%b",
                         t, a.pc_hold, a.fd_hold, a.fd_bubble, a.dx_bubble, a.xm_bubble, a.fpu_busy,
                         a.fpu_done, a.fpu_dst_o, a.fpu_overlap_err, e.pc_hold, e.fd_hold, e.fd_bubble,
                         e.dx_bubble, e.xm_bubble, e.fpu_busy, e.fpu_done, e.fpu_dst_o, e.fpu_overlap_err);
            end
        end
    end

    initial begin
        stim_t s;
        s = quiet();
        s.rst = 1'b0;
        apply(s);
        @(posedge clk);
        #1;

        // Reset with a start pending, then release.
        s = quiet(); s.rst = 1'b0; s.x_fpu_start = 1'b1; s.x_fpu_dst = 5'd7;
        step(s); step(s);
        s = quiet(); step(s); step(s);

        // Load-use on rs, then on r0.
        s = quiet(); s.x_valid = 1; s.x_mem_read = 1; s.x_dst = 5'd5;
        s.d_valid = 1; s.d_rs = 5'd5; s.d_use_rs = 1;
        step(s);
        s = quiet(); s.d_valid = 1; s.d_rs = 5'd5; s.d_use_rs = 1; step(s);
        s = quiet(); s.x_valid = 1; s.x_mem_read = 1; s.x_dst = 5'd0;
        s.d_valid = 1; s.d_rs = 5'd0; s.d_use_rs = 1; s.d_rt = 5'd0; s.d_use_rt = 1;
        step(s);

        // FPU to f3 with dependent Decode reading f3; held until release.
        s = quiet(); s.x_fpu_start = 1; s.x_fpu_dst = 5'd3;
        s.d_valid = 1; s.d_fs = 5'd3; s.d_use_fs = 1;
        step(s);
        s.x_fpu_start = 0;
        repeat (5) step(s);
        // FPU to f0 with unrelated integer op, then f0 reader (FP reg 0 is a real hazard).
        s = quiet(); s.x_fpu_start = 1; s.x_fpu_dst = 5'd0; step(s);
        s = quiet(); s.d_valid = 1; s.d_rs = 5'd3; s.d_use_rs = 1; step(s);
        s = quiet(); s.d_valid = 1; s.d_ft = 5'd0; s.d_use_ft = 1; repeat (4) step(s);

        // Second FPU op in Decode during BUSY, overlapping start at cycle 2.
        s = quiet(); s.x_fpu_start = 1; s.x_fpu_dst = 5'd9; step(s);
        s = quiet(); s.d_valid = 1; s.d_is_fpu = 1; step(s);
        s.x_fpu_start = 1; s.x_fpu_dst = 5'd11; step(s);
        s.x_fpu_start = 0; repeat (4) step(s);

        // Branch over load-use, branch with start, branch during BUSY.
        s = quiet(); s.m_branch_taken = 1; s.x_valid = 1; s.x_mem_read = 1; s.x_dst = 5'd4;
        s.d_valid = 1; s.d_rt = 5'd4; s.d_use_rt = 1; step(s);
        s = quiet(); s.m_branch_taken = 1; s.x_fpu_start = 1; s.x_fpu_dst = 5'd2; step(s);
        s = quiet(); step(s);
        s = quiet(); s.x_fpu_start = 1; s.x_fpu_dst = 5'd6; step(s);
        s = quiet(); step(s);
        s.m_branch_taken = 1; step(s);
        s.m_branch_taken = 0; repeat (3) step(s);

        // Reset at cycle 2 of BUSY.
        s = quiet(); s.x_fpu_start = 1; s.x_fpu_dst = 5'd8; step(s);
        s = quiet(); step(s);
        s.rst = 0; step(s);
        s.rst = 1; repeat (4) step(s);

        // Random traffic over a narrow register range so hazards are frequent.
        for (int i = 0; i < 3000; i++) begin
            s = quiet();
            s.rst            = ($urandom_range(0, 59) != 0);
            s.d_valid        = ($urandom_range(0, 3) != 0);
            s.d_rs           = REG_W'($urandom_range(0, 3));
            s.d_rt           = REG_W'($urandom_range(0, 3));
            s.d_use_rs       = 1'($urandom_range(0, 1));
            s.d_use_rt       = 1'($urandom_range(0, 1));
            s.d_is_fpu       = ($urandom_range(0, 5) == 0);
            s.d_fs           = REG_W'($urandom_range(0, 3));
            s.d_ft           = REG_W'($urandom_range(0, 3));
            s.d_use_fs       = 1'($urandom_range(0, 1));
            s.d_use_ft       = 1'($urandom_range(0, 1));
            s.x_valid        = ($urandom_range(0, 3) != 0);
            s.x_mem_read     = 1'($urandom_range(0, 1));
            s.x_dst          = REG_W'($urandom_range(0, 3));
            s.x_fpu_start    = ($urandom_range(0, 4) == 0);
            s.x_fpu_dst      = REG_W'($urandom_range(0, 3));
            s.m_branch_taken = ($urandom_range(0, 7) == 0);
            step(s);
        end

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
